// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN convolution datapath.
package cnn_pkg;

    localparam int DATA_W      = 32;
    localparam int FILTER_TAPS = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic signed [DATA_W-1:0] data_t;

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate: acc + a*b, signed, wrapping at the data width.
module mac_unit
    import cnn_pkg::*;
(
    input  data_t i_acc,
    input  data_t i_a,
    input  data_t i_b,
    output data_t o_acc_next
);

    // Low word of the signed product added to the running sum; overflow wraps.
    assign o_acc_next = i_acc + (i_a * i_b);

endmodule

// File: rtl/dot_product_module.sv
// 9-tap sequential dot product of a 3x3 image window and 3x3 kernel, one MAC per clock.
module dot_product_module
    import cnn_pkg::*;
#(
    parameter int filtersize = FILTER_TAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              initate,
    input  logic [DATA_W-1:0] img_bit_0,
    input  logic [DATA_W-1:0] img_bit_1,
    input  logic [DATA_W-1:0] img_bit_2,
    input  logic [DATA_W-1:0] img_bit_3,
    input  logic [DATA_W-1:0] img_bit_4,
    input  logic [DATA_W-1:0] img_bit_5,
    input  logic [DATA_W-1:0] img_bit_6,
    input  logic [DATA_W-1:0] img_bit_7,
    input  logic [DATA_W-1:0] img_bit_8,
    input  logic [DATA_W-1:0] filter_0,
    input  logic [DATA_W-1:0] filter_1,
    input  logic [DATA_W-1:0] filter_2,
    input  logic [DATA_W-1:0] filter_3,
    input  logic [DATA_W-1:0] filter_4,
    input  logic [DATA_W-1:0] filter_5,
    input  logic [DATA_W-1:0] filter_6,
    input  logic [DATA_W-1:0] filter_7,
    input  logic [DATA_W-1:0] filter_8,
    output logic [DATA_W-1:0] Result_out,
    output logic              ready_dot
);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_initate_q;
    logic       w_start;
    logic       w_last;
    logic [3:0] r_idx;
    data_t      r_acc;
    data_t      w_acc_next;
    data_t      r_result;
    logic       r_ready;
    data_t      r_img  [FILTER_TAPS];
    data_t      r_filt [FILTER_TAPS];
    data_t      w_img  [FILTER_TAPS];
    data_t      w_filt [FILTER_TAPS];

    assign w_img[0] = img_bit_0;
    assign w_img[1] = img_bit_1;
    assign w_img[2] = img_bit_2;
    assign w_img[3] = img_bit_3;
    assign w_img[4] = img_bit_4;
    assign w_img[5] = img_bit_5;
    assign w_img[6] = img_bit_6;
    assign w_img[7] = img_bit_7;
    assign w_img[8] = img_bit_8;

    assign w_filt[0] = filter_0;
    assign w_filt[1] = filter_1;
    assign w_filt[2] = filter_2;
    assign w_filt[3] = filter_3;
    assign w_filt[4] = filter_4;
    assign w_filt[5] = filter_5;
    assign w_filt[6] = filter_6;
    assign w_filt[7] = filter_7;
    assign w_filt[8] = filter_8;

    // A held-high initate must not retrigger, so only the 0->1 transition starts a run.
    assign w_start = initate & ~r_initate_q;
    assign w_last  = (r_idx == 4'(filtersize - 1));

    mac_unit u_mac (
        .i_acc      (r_acc),
        .i_a        (r_img[r_idx]),
        .i_b        (r_filt[r_idx]),
        .o_acc_next (w_acc_next)
    );

    // Start-edge detector history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_initate_q <= 1'b0;
        end else begin
            r_initate_q <= initate;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; starts arriving during MAC are deliberately dropped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) w_state_next = MAC;
                else         w_state_next = IDLE;
            end
            MAC: begin
                if (w_last) w_state_next = DONE;
                else        w_state_next = MAC;
            end
            DONE: begin
                if (w_start) w_state_next = MAC;
                else         w_state_next = DONE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, accumulation and result/valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_idx    <= 4'd0;
            r_result <= '0;
            r_ready  <= 1'b0;
            for (int i = 0; i < FILTER_TAPS; i++) begin
                r_img[i]  <= '0;
                r_filt[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_acc   <= '0;
                        r_idx   <= 4'd0;
                        r_ready <= 1'b0;
                        for (int i = 0; i < FILTER_TAPS; i++) begin
                            r_img[i]  <= w_img[i];
                            r_filt[i] <= w_filt[i];
                        end
                    end
                end
                MAC: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + 4'd1;
                    if (w_last) begin
                        r_result <= w_acc_next;
                        r_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_acc <= '0;
                    r_idx <= 4'd0;
                end
            endcase
        end
    end

    assign Result_out = r_result;
    assign ready_dot  = r_ready;

endmodule

// File: tb/tb_dot_product_module.sv
// Self-checking bench for dot_product_module: directed and random windows against a reference sum.
module tb_dot_product_module;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        initate;
    logic [31:0] tb_img  [9];
    logic [31:0] tb_filt [9];
    logic [31:0] Result_out;
    logic        ready_dot;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    bit toggle_mid = 1'b0;
    bit hold_high  = 1'b0;

    always #5 clk = ~clk;

    dot_product_module dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .initate    (initate),
        .img_bit_0  (tb_img[0]),
        .img_bit_1  (tb_img[1]),
        .img_bit_2  (tb_img[2]),
        .img_bit_3  (tb_img[3]),
        .img_bit_4  (tb_img[4]),
        .img_bit_5  (tb_img[5]),
        .img_bit_6  (tb_img[6]),
        .img_bit_7  (tb_img[7]),
        .img_bit_8  (tb_img[8]),
        .filter_0   (tb_filt[0]),
        .filter_1   (tb_filt[1]),
        .filter_2   (tb_filt[2]),
        .filter_3   (tb_filt[3]),
        .filter_4   (tb_filt[4]),
        .filter_5   (tb_filt[5]),
        .filter_6   (tb_filt[6]),
        .filter_7   (tb_filt[7]),
        .filter_8   (tb_filt[8]),
        .Result_out (Result_out),
        .ready_dot  (ready_dot)
    );

    // Reference: exact signed products summed, reduced modulo 2^32 after every tap.
    function automatic logic [31:0] ref_dot();
        longint s = 0;
        for (int i = 0; i < 9; i++) begin
            s = (s + longint'($signed(tb_img[i])) * longint'($signed(tb_filt[i])))
                & 64'h0000_0000_FFFF_FFFF;
        end
        return s[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_window(input logic [31:0] img_base, input logic [31:0] img_step,
                              input logic [31:0] filt_val);
        for (int i = 0; i < 9; i++) begin
            tb_img[i]  = img_base + img_step * 32'(i);
            tb_filt[i] = filt_val;
        end
    endtask

    task automatic launch();
        @(negedge clk);
        initate = 1'b1;
    endtask

    // Waits for completion; the start edge is the posedge following the current time.
    task automatic wait_done(input string tag, input logic [31:0] exp, input logic [31:0] prev);
        int first = 0;
        for (int n = 1; n <= 30 && first == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check({tag, "_ready_low_at_start"}, {31'd0, ready_dot}, 32'd0);
                check({tag, "_result_held"}, Result_out, prev);
                initate = hold_high;
            end
            if (toggle_mid) begin
                if (n == 2) begin
                    for (int i = 0; i < 9; i++) begin
                        tb_img[i]  = $urandom;
                        tb_filt[i] = $urandom;
                    end
                end
                if (n == 3 || n == 6) initate = 1'b1;
                if (n == 5 || n == 7) initate = 1'b0;
            end
            if (ready_dot === 1'b1) first = n;
        end
        check({tag, "_latency"}, 32'(first), 32'd10);
        check({tag, "_result"}, Result_out, exp);
    endtask

    initial begin
        logic [31:0] exp;
        logic [31:0] prev;
        int          drops;

        rst_n   = 1'b0;
        initate = 1'b0;
        set_window(32'd0, 32'd0, 32'd0);
        #12;
        check("reset_result", Result_out, 32'd0);
        check("reset_ready", {31'd0, ready_dot}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Filters all 1, image 1..9.
        set_window(32'd1, 32'd1, 32'd1);
        exp = ref_dot();
        check("model_45", exp, 32'h0000_002D);
        launch();
        wait_done("sum45", exp, 32'd0);
        prev = exp;

        // Filters all -1, image all 2; initate then held high.
        set_window(32'd2, 32'd0, 32'hFFFF_FFFF);
        exp = ref_dot();
        check("model_neg18", exp, 32'hFFFF_FFEE);
        hold_high = 1'b1;
        launch();
        wait_done("neg18", exp, prev);
        hold_high = 1'b0;
        drops = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (ready_dot !== 1'b1 || Result_out !== exp) drops++;
        end
        check("held_high_no_retrigger", 32'(drops), 32'd0);
        initate = 1'b0;
        prev = exp;

        // Product wrap: 0x10000 * 0x10000 on tap 0.
        set_window(32'd0, 32'd0, 32'd0);
        tb_img[0]  = 32'h0001_0000;
        tb_filt[0] = 32'h0001_0000;
        launch();
        wait_done("wrap_zero", 32'h0000_0000, prev);
        prev = 32'h0000_0000;

        // 0x7FFFFFFF * 2 on tap 0.
        set_window(32'd0, 32'd0, 32'd0);
        tb_img[0]  = 32'h7FFF_FFFF;
        tb_filt[0] = 32'h0000_0002;
        launch();
        wait_done("wrap_max", 32'hFFFF_FFFE, prev);
        prev = 32'hFFFF_FFFE;

        // Retrigger with filters 2, inputs scrambled and initate toggled mid-run.
        set_window(32'd1, 32'd1, 32'd2);
        exp = ref_dot();
        check("model_90", exp, 32'h0000_005A);
        toggle_mid = 1'b1;
        launch();
        wait_done("retrig90", exp, prev);
        toggle_mid = 1'b0;
        prev = exp;

        // Random windows.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 9; i++) begin
                tb_img[i]  = (r < 3) ? $urandom : $urandom_range(0, 255);
                tb_filt[i] = (r < 3) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
            end
            exp = ref_dot();
            launch();
            wait_done($sformatf("rand%0d", r), exp, prev);
            prev = exp;
        end

        // Reset during MAC: async clear, then a start with initate already high at release.
        set_window(32'd3, 32'd7, 32'd5);
        launch();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            initate = 1'b0;
        end
        check("pre_reset_result", Result_out, prev);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_result", Result_out, 32'd0);
        check("abort_ready", {31'd0, ready_dot}, 32'd0);
        set_window(32'd1, 32'd1, 32'd1);
        exp = ref_dot();
        initate = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_done("post_reset", exp, 32'd0);
        initate = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
